// File: rtl/multi_dataflow_kernel_adapter_gen.sv
// Job-length adapter between wrapper-side streams and a dataflow kernel.
// Each job latches per-channel beat limits on start, forwards stream
// handshakes combinationally until each channel has reached its limit, and
// completes once every output channel has delivered its quota. Output beats
// offered past the limit are drained from the kernel and flagged as errors.
module multi_dataflow_kernel_adapter_gen #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic [N_IN*CNT_W-1:0]  n_in_i,
    input  logic [N_OUT*CNT_W-1:0] n_out_i,

    input  logic [N_IN-1:0]        in_valid_i,
    output logic [N_IN-1:0]        in_ready_o,
    input  logic [N_IN*DW-1:0]     in_data_i,

    output logic [N_IN-1:0]        k_in_valid_o,
    input  logic [N_IN-1:0]        k_in_ready_i,
    output logic [N_IN*DW-1:0]     k_in_data_o,

    input  logic [N_OUT-1:0]       k_out_valid_i,
    output logic [N_OUT-1:0]       k_out_ready_o,
    input  logic [N_OUT*DW-1:0]    k_out_data_i,

    output logic [N_OUT-1:0]       out_valid_o,
    input  logic [N_OUT-1:0]       out_ready_i,
    output logic [N_OUT*DW-1:0]    out_data_o,

    output logic                   idle_o,
    output logic                   ready_o,
    output logic                   done_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] lim_in_q  [N_IN];
    logic [CNT_W-1:0] cnt_in_q  [N_IN];
    logic [CNT_W-1:0] lim_out_q [N_OUT];
    logic [CNT_W-1:0] cnt_out_q [N_OUT];
    logic             err_q;

    logic             run;
    logic [N_IN-1:0]  in_open;
    logic [N_IN-1:0]  in_fire;
    logic [N_IN-1:0]  in_full;
    logic [N_OUT-1:0] out_open;
    logic [N_OUT-1:0] out_fire;
    logic [N_OUT-1:0] out_drop;
    logic [N_OUT-1:0] out_done_nxt;

    // Data is never registered: the kernel sees the wrapper payload directly.
    assign k_in_data_o = in_data_i;
    assign out_data_o  = k_out_data_i;

    // Per-channel gate, handshake and completion terms derived from the counters.
    always_comb begin
        // NOTE: every signal gets a default before the loops so no path leaves it unassigned (no latch).
        run          = (state_q == RUN);
        in_open      = '0;
        in_fire      = '0;
        in_full      = '0;
        out_open     = '0;
        out_fire     = '0;
        out_drop     = '0;
        out_done_nxt = '0;
        for (int c = 0; c < N_IN; c++) begin
            in_full[c] = (cnt_in_q[c] == lim_in_q[c]);
            in_open[c] = run && (cnt_in_q[c] < lim_in_q[c]);
            in_fire[c] = in_open[c] && in_valid_i[c] && k_in_ready_i[c];
        end
        for (int c = 0; c < N_OUT; c++) begin
            out_open[c]     = run && (cnt_out_q[c] < lim_out_q[c]);
            out_fire[c]     = out_open[c] && k_out_valid_i[c] && out_ready_i[c];
            out_drop[c]     = run && !out_open[c] && k_out_valid_i[c];
            // A channel is complete next cycle if it already is, or its last beat lands now.
            out_done_nxt[c] = (cnt_out_q[c] == lim_out_q[c]) ||
                              (out_fire[c] && ((cnt_out_q[c] + CNT_W'(1)) == lim_out_q[c]));
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear_i overrides everything except reset.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_i) state_d = RUN;
                RUN:     if (&out_done_nxt) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Limit latching, beat counting and sticky overrun error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: these arrays are a handful of ordinary flops, not a RAM, so they take reset like any register.
            for (int c = 0; c < N_IN; c++) begin
                lim_in_q[c] <= '0;
                cnt_in_q[c] <= '0;
            end
            for (int c = 0; c < N_OUT; c++) begin
                lim_out_q[c] <= '0;
                cnt_out_q[c] <= '0;
            end
            err_q <= 1'b0;
        end else if (clear_i) begin
            for (int c = 0; c < N_IN; c++) begin
                cnt_in_q[c] <= '0;
            end
            for (int c = 0; c < N_OUT; c++) begin
                cnt_out_q[c] <= '0;
            end
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && start_i) begin
            for (int c = 0; c < N_IN; c++) begin
                lim_in_q[c] <= n_in_i[c*CNT_W +: CNT_W];
                cnt_in_q[c] <= '0;
            end
            for (int c = 0; c < N_OUT; c++) begin
                lim_out_q[c] <= n_out_i[c*CNT_W +: CNT_W];
                cnt_out_q[c] <= '0;
            end
        end else begin
            // Fire terms are only true below the limit, so counters saturate at it.
            for (int c = 0; c < N_IN; c++) begin
                if (in_fire[c]) cnt_in_q[c] <= cnt_in_q[c] + CNT_W'(1);
            end
            for (int c = 0; c < N_OUT; c++) begin
                if (out_fire[c]) cnt_out_q[c] <= cnt_out_q[c] + CNT_W'(1);
            end
            if (|out_drop) err_q <= 1'b1;
        end
    end

    // Stream gating and status flags.
    always_comb begin
        in_ready_o    = '0;
        k_in_valid_o  = '0;
        out_valid_o   = '0;
        k_out_ready_o = '0;
        for (int c = 0; c < N_IN; c++) begin
            k_in_valid_o[c] = in_open[c] & in_valid_i[c];
            in_ready_o[c]   = in_open[c] & k_in_ready_i[c];
        end
        for (int c = 0; c < N_OUT; c++) begin
            out_valid_o[c]   = out_open[c] & k_out_valid_i[c];
            // Surplus kernel beats are accepted and discarded so the kernel never stalls.
            k_out_ready_o[c] = (out_open[c] & out_ready_i[c]) | out_drop[c];
        end
        idle_o  = (state_q == IDLE);
        done_o  = (state_q == DONE);
        ready_o = run && (&in_full);
        err_o   = err_q;
    end

endmodule

// File: tb/tb_multi_dataflow_kernel_adapter_gen.sv
// Directed bench for the kernel adapter. The main instance uses two input and
// one output channel; a second instance with two output channels keeps the job
// running while one output channel is overrun.
module tb_multi_dataflow_kernel_adapter_gen;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Main instance: N_IN=2, N_OUT=1.
    logic        start, clear;
    logic [31:0] n_in;
    logic [15:0] n_out;
    logic [1:0]  in_valid, in_ready, k_in_valid, k_in_ready;
    logic [63:0] in_data, k_in_data;
    logic [0:0]  k_out_valid, k_out_ready, out_valid, out_ready;
    logic [31:0] k_out_data, out_data;
    logic        idle, ready, done, err;

    // Overrun instance: N_IN=1, N_OUT=2.
    logic        start_b, clear_b;
    logic [15:0] n_in_b;
    logic [31:0] n_out_b;
    logic [0:0]  in_valid_b, in_ready_b, k_in_valid_b, k_in_ready_b;
    logic [31:0] in_data_b, k_in_data_b;
    logic [1:0]  k_out_valid_b, k_out_ready_b, out_valid_b, out_ready_b;
    logic [63:0] k_out_data_b, out_data_b;
    logic        idle_b, ready_b, done_b, err_b;

    int hs;

    multi_dataflow_kernel_adapter_gen #(.N_IN(2), .N_OUT(1), .DW(32), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start), .clear_i(clear),
        .n_in_i(n_in), .n_out_i(n_out),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .k_in_valid_o(k_in_valid), .k_in_ready_i(k_in_ready), .k_in_data_o(k_in_data),
        .k_out_valid_i(k_out_valid), .k_out_ready_o(k_out_ready), .k_out_data_i(k_out_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .idle_o(idle), .ready_o(ready), .done_o(done), .err_o(err)
    );

    multi_dataflow_kernel_adapter_gen #(.N_IN(1), .N_OUT(2), .DW(32), .CNT_W(16)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_b), .clear_i(clear_b),
        .n_in_i(n_in_b), .n_out_i(n_out_b),
        .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .in_data_i(in_data_b),
        .k_in_valid_o(k_in_valid_b), .k_in_ready_i(k_in_ready_b), .k_in_data_o(k_in_data_b),
        .k_out_valid_i(k_out_valid_b), .k_out_ready_o(k_out_ready_b), .k_out_data_i(k_out_data_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .out_data_o(out_data_b),
        .idle_o(idle_b), .ready_o(ready_b), .done_o(done_b), .err_o(err_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // ---------------- reset, with every stream offering traffic ----------------
        rst_i = 1'b1; start = 1'b0; clear = 1'b0; n_in = '0; n_out = '0;
        in_valid = 2'b11; k_in_ready = 2'b11; in_data = {32'hB1B1_0001, 32'hA0A0_0000};
        k_out_valid = 1'b1; out_ready = 1'b1; k_out_data = 32'hC0DE_0000;
        start_b = 1'b0; clear_b = 1'b0; n_in_b = '0; n_out_b = '0;
        in_valid_b = '0; k_in_ready_b = '0; in_data_b = '0;
        k_out_valid_b = '0; out_ready_b = '0; k_out_data_b = '0;
        step(); step(); #1;
        check("rst_idle", idle, 1'b1);
        check("rst_ready", ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 2'b00);
        check("rst_k_in_valid", k_in_valid, 2'b00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_k_out_ready", k_out_ready, 1'b0);
        check("rst_idle_b", idle_b, 1'b1);

        // ---------------- basic job: n_in={ch1=1,ch0=4}, n_out=4 ----------------
        rst_i = 1'b0; k_out_valid = 1'b0;
        n_in = {16'd1, 16'd4}; n_out = 16'd4; start = 1'b1;
        #1 check("basic_idle_pre", idle, 1'b1);
        step();
        start = 1'b0;
        #1;                                              // RUN cycle 1
        check("basic_idle_run", idle, 1'b0);
        check("basic_in_ready_r1", in_ready, 2'b11);
        check("basic_k_in_valid_r1", k_in_valid, 2'b11);
        check("basic_k_in_data", k_in_data, {32'hB1B1_0001, 32'hA0A0_0000});
        check("basic_ready_r1", ready, 1'b0);
        step();
        // Second start mid-run with zero limits must be ignored.
        start = 1'b1; n_in = '0; n_out = '0;
        #1 check("basic_in_ready_r2", in_ready, 2'b01);
        step();
        start = 1'b0;
        #1 check("basic_ready_r3", ready, 1'b0);
        step();
        #1;
        check("basic_ready_r4", ready, 1'b0);
        check("basic_in_ready_r4", in_ready, 2'b01);
        step();
        #1;                                              // ch0 has 4 beats
        check("basic_ready_after4", ready, 1'b1);
        check("overrun_in_ready", in_ready, 2'b00);
        check("overrun_k_in_valid", k_in_valid, 2'b00);
        step();
        #1;
        check("overrun_hold_ready", ready, 1'b1);
        check("overrun_hold_in_ready", in_ready, 2'b00);
        k_out_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            k_out_data = 32'hC0DE_0000 + 32'(i);
            #1;
            check("basic_out_valid", out_valid, 1'b1);
            check("basic_k_out_ready", k_out_ready, 1'b1);
            check("basic_out_data", out_data, 32'hC0DE_0000 + 32'(i));
            check("basic_no_done", done, 1'b0);
            step();
        end
        #1;
        check("basic_done", done, 1'b1);
        check("basic_done_idle", idle, 1'b0);
        check("basic_done_out_valid", out_valid, 1'b0);
        check("basic_done_k_out_ready", k_out_ready, 1'b0);
        check("basic_done_ready", ready, 1'b0);
        step();
        #1;
        check("basic_done_one_cycle", done, 1'b0);
        check("basic_back_idle", idle, 1'b1);
        check("basic_idle_in_ready", in_ready, 2'b00);

        // ---------------- zero limits ----------------
        k_out_valid = 1'b0; n_in = '0; n_out = '0; start = 1'b1;
        step();
        start = 1'b0;
        #1;
        check("zero_run_done", done, 1'b0);
        check("zero_run_idle", idle, 1'b0);
        check("zero_run_ready", ready, 1'b1);
        check("zero_in_ready", in_ready, 2'b00);
        check("zero_k_in_valid", k_in_valid, 2'b00);
        check("zero_out_valid", out_valid, 1'b0);
        step();
        #1 check("zero_done", done, 1'b1);
        step();
        #1;
        check("zero_after_done", done, 1'b0);
        check("zero_after_idle", idle, 1'b1);

        // ---------------- abort after 2 of 4 output beats ----------------
        n_in = '0; n_out = 16'd4; start = 1'b1;
        step();
        start = 1'b0; k_out_valid = 1'b1; out_ready = 1'b1;
        step(); step();
        k_out_valid = 1'b0; clear = 1'b1;
        #1 check("abort_pre_done", done, 1'b0);
        step();
        clear = 1'b0;
        #1;
        check("abort_idle", idle, 1'b1);
        check("abort_no_done", done, 1'b0);
        step();
        #1 check("abort_no_done_later", done, 1'b0);
        // Fresh job after the abort: 2 input beats on ch0, 2 output beats.
        n_in = {16'd0, 16'd2}; n_out = 16'd2; in_valid = 2'b01; k_in_ready = 2'b01; start = 1'b1;
        step();
        start = 1'b0; k_out_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("restart_in_ready1", in_ready, 2'b01);
        check("restart_out_valid1", out_valid, 1'b1);
        step();
        #1;
        check("restart_in_ready2", in_ready, 2'b01);
        check("restart_no_done", done, 1'b0);
        step();
        #1 check("restart_done", done, 1'b1);
        step();
        #1;
        check("restart_idle", idle, 1'b1);
        check("restart_done_clr", done, 1'b0);

        // ---------------- backpressure: out_ready toggling ----------------
        in_valid = 2'b00; n_in = '0; n_out = 16'd4; start = 1'b1;
        step();
        start = 1'b0; hs = 0;
        for (int i = 0; i < 7; i++) begin
            out_ready = ((i % 2) == 0);
            #1;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_k_out_ready", k_out_ready, out_ready);
            check("bp_no_done", done, 1'b0);
            if (out_valid[0] && out_ready[0]) hs++;
            step();
        end
        check("bp_handshakes", 64'(hs), 64'd4);
        #1 check("bp_done", done, 1'b1);
        step();
        #1 check("bp_idle", idle, 1'b1);

        // ---------------- reset in the middle of a job ----------------
        n_out = 16'd4; start = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b1; k_out_valid = 1'b1; in_valid = 2'b11; k_in_ready = 2'b11;
        step();
        rst_i = 1'b1;
        #1 check("midrst_pre_idle", idle, 1'b0);
        step();
        #1;
        check("midrst_idle", idle, 1'b1);
        check("midrst_ready", ready, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_k_out_ready", k_out_ready, 1'b0);
        check("midrst_in_ready", in_ready, 2'b00);
        check("midrst_k_in_valid", k_in_valid, 2'b00);
        rst_i = 1'b0; k_out_valid = 1'b0;
        step();
        #1;
        check("midrst_discard_done", done, 1'b0);
        check("midrst_still_idle", idle, 1'b1);

        // ---------------- output overrun on the two-output instance ----------------
        n_in_b = '0; n_out_b = {16'd2, 16'd1}; start_b = 1'b1;
        step();
        start_b = 1'b0; k_out_valid_b = 2'b01; out_ready_b = 2'b11;
        #1;
        check("ovr_first_valid", out_valid_b, 2'b01);
        check("ovr_first_kready", k_out_ready_b, 2'b11);
        step();
        #1;
        check("ovr_second_valid", out_valid_b, 2'b00);
        check("ovr_second_kready", k_out_ready_b, 2'b11);
        check("ovr_err_pre", err_b, 1'b0);
        step();
        k_out_valid_b = 2'b00;
        #1;
        check("ovr_err_set", err_b, 1'b1);
        check("ovr_still_run", idle_b, 1'b0);
        check("ovr_no_done", done_b, 1'b0);
        step();
        #1 check("ovr_err_sticky", err_b, 1'b1);
        clear_b = 1'b1;
        step();
        clear_b = 1'b0;
        #1;
        check("ovr_err_cleared", err_b, 1'b0);
        check("ovr_clear_idle", idle_b, 1'b1);
        check("ovr_clear_no_done", done_b, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_dataflow_kernel_adapter_gen.md
MULTI_DATAFLOW_KERNEL_ADAPTER_GEN -- requirements
Module: multi_dataflow_kernel_adapter_gen

Interface
REQ-001 SHALL have parameter N_IN, default 2, meaning the number of kernel input stream channels (1..8).
REQ-002 SHALL have parameter N_OUT, default 1, meaning the number of kernel output stream channels (1..8).
REQ-003 SHALL have parameter DW, default 32, meaning the data width of every stream channel.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the width of the per-channel job-length limits and counters.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port start_i  in  1  job start pulse.
REQ-007 SHALL have port clear_i  in  1  synchronous job abort.
REQ-008 SHALL have port n_in_i  in  N_IN*CNT_W  input beats per channel for the job (channel c at bits [c*CNT_W +: CNT_W]).
REQ-009 SHALL have port n_out_i  in  N_OUT*CNT_W  output beats per channel for the job.
REQ-010 SHALL have ports in_valid_i/in_ready_o/in_data_i  in/out/in  N_IN/N_IN/N_IN*DW  wrapper-side input streams.
REQ-011 SHALL have ports k_in_valid_o/k_in_ready_i/k_in_data_o  out/in/out  N_IN/N_IN/N_IN*DW  kernel-side input streams.
REQ-012 SHALL have ports k_out_valid_i/k_out_ready_o/k_out_data_i  in/out/in  N_OUT/N_OUT/N_OUT*DW  kernel-side output streams.
REQ-013 SHALL have ports out_valid_o/out_ready_i/out_data_o  out/in/out  N_OUT/N_OUT/N_OUT*DW  wrapper-side output streams.
REQ-014 SHALL have flag outputs idle_o, ready_o, done_o, err_o, each 1 bit.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL, in IDLE on start_i=1, latch n_in_i/n_out_i into limit registers, zero all counters, and enter RUN next cycle.
REQ-017 SHALL ignore start_i outside IDLE; latched limits do not change until the next accepted start.
REQ-018 SHALL, in RUN, forward input channel c combinationally (k_in_valid_o[c]=in_valid_i[c], in_ready_o[c]=k_in_ready_i[c], data pass-through) while cnt_in[c] < lim_in[c]; otherwise drive k_in_valid_o[c]=0 and in_ready_o[c]=0.
REQ-019 SHALL increment cnt_in[c] on each forwarded valid&ready beat; counters never exceed their limit.
REQ-020 SHALL, in RUN, forward output channel c combinationally while cnt_out[c] < lim_out[c] and increment cnt_out[c] on each valid&ready beat.
REQ-021 SHALL, for an output beat offered when cnt_out[c] == lim_out[c], drive k_out_ready_o[c]=1 and out_valid_o[c]=0 (beat dropped) and set err_o sticky.
REQ-022 SHALL gate all streams (valids and readies 0) in IDLE and DONE.
REQ-023 SHALL drive ready_o=1 in RUN when every cnt_in[c] == lim_in[c].
REQ-024 SHALL move RUN->DONE on the cycle after every cnt_out[c] == lim_out[c] (including the final handshake cycle's increment), and DONE->IDLE unconditionally next cycle.
REQ-025 SHALL assert done_o=1 for exactly the one cycle spent in DONE.
REQ-026 SHALL treat a limit of 0 as already complete for that channel; all limits 0 gives RUN then DONE on consecutive cycles.
REQ-027 SHALL drive idle_o=1 exactly when the state is IDLE.
REQ-028 SHALL, on clear_i=1 in any state, go to IDLE next cycle, zero counters, not assert done_o, and clear err_o; clear_i has priority over start_i.
REQ-029 SHALL add zero cycles of latency on the data path; only counters and flags are registered.

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, enter IDLE and zero counters, limits, and err_o.
REQ-031 SHALL hold the outputs at reset as follows: idle_o=1, ready_o=0, done_o=0, err_o=0, all valids/readies 0.
REQ-032 SHALL give rst_i priority over clear_i and start_i; reset mid-job discards the job without done_o.

Verification
REQ-033 SHALL cover a basic job: N_IN=2, N_OUT=1, n_in={4,1}, n_out={4}, all streams always ready -> ready_o after 4th ch0 beat; done_o for one cycle after the 4th output beat; then idle_o=1.
REQ-034 SHALL cover input overrun: a 5th beat offered on ch0 with lim 4 -> in_ready_o[0]=0, the beat is not forwarded, and cnt_in stays 4.
REQ-035 SHALL cover output overrun: the kernel emits a 2nd beat with lim_out=1 -> out_valid_o=0, k_out_ready_o=1, err_o=1 held until clear_i.
REQ-036 SHALL cover zero limits: all n_in and n_out = 0 -> done_o is asserted 2 cycles after start_i and no stream handshake occurs.
REQ-037 SHALL cover abort: clear_i after 2 of 4 output beats -> idle_o=1 next cycle and no done_o; a new start then runs a full job correctly.
REQ-038 SHALL cover backpressure and a mid-job reset: out_ready_i toggling 1/0 keeps cnt_out consistent with the wrapper-side handshakes, and rst_i mid-RUN returns all outputs to their reset values next cycle.
